// File: rtl/subset_scan_ctrl.sv
// Sweeps every grid position into the Subset evaluator, one per cycle,
// and counts how many of its responses report the point as activated.
module subset_scan_ctrl #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [23:0]      central,
  input  logic [23:0]      radius_square,
  input  logic [1:0]       mode,
  output logic             sub_en,
  output logic [23:0]      sub_central,
  output logic [23:0]      sub_radius_square,
  output logic [1:0]       sub_mode,
  output logic [7:0]       sub_position,
  input  logic             sub_valid,
  input  logic             sub_activated,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] candidate
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] TOTAL  = CNT_W'(GRID_W * GRID_H);
  localparam logic [3:0]       X_LAST = 4'(GRID_W);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] resp_cnt_q, resp_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [3:0]       x_q, x_d;
  logic [3:0]       y_q, y_d;
  logic             sub_en_q, sub_en_d;
  logic [7:0]       sub_pos_q, sub_pos_d;
  logic [23:0]      sub_central_q, sub_central_d;
  logic [23:0]      sub_rsq_q, sub_rsq_d;
  logic [1:0]       sub_mode_q, sub_mode_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cand_q, cand_d;

  logic             resp_take;
  logic [CNT_W-1:0] resp_cnt_nx;
  logic [CNT_W-1:0] acc_nx;

  // Responses count in both ISSUE and DRAIN so a response landing on the
  // same cycle as an issue is never lost; surplus responses are dropped.
  always_comb begin
    resp_take   = (state_q == ISSUE || state_q == DRAIN) && sub_valid &&
                  (resp_cnt_q != TOTAL);
    resp_cnt_nx = resp_cnt_q + {{(CNT_W-1){1'b0}}, resp_take};
    acc_nx      = acc_q + {{(CNT_W-1){1'b0}}, resp_take & sub_activated};
  end

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    resp_cnt_d    = resp_cnt_q;
    acc_d         = acc_q;
    x_d           = x_q;
    y_d           = y_q;
    sub_en_d      = 1'b0;
    sub_pos_d     = sub_pos_q;
    sub_central_d = sub_central_q;
    sub_rsq_d     = sub_rsq_q;
    sub_mode_d    = sub_mode_q;
    busy_d        = busy_q;
    valid_d       = 1'b0;
    cand_d        = cand_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          sub_central_d = central;
          sub_rsq_d     = radius_square;
          sub_mode_d    = mode;
          issue_cnt_d   = '0;
          resp_cnt_d    = '0;
          acc_d         = '0;
          x_d           = 4'd1;
          y_d           = 4'd1;
          busy_d        = 1'b1;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        resp_cnt_d = resp_cnt_nx;
        acc_d      = acc_nx;
        if (issue_cnt_q != TOTAL) begin
          sub_en_d    = 1'b1;
          sub_pos_d   = {x_q, y_q};
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = 4'd1;
            y_d = y_q + 4'd1;
          end else begin
            x_d = x_q + 4'd1;
          end
        end else if (resp_cnt_nx == TOTAL) begin
          valid_d = 1'b1;
          cand_d  = acc_nx;
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        resp_cnt_d = resp_cnt_nx;
        acc_d      = acc_nx;
        if (resp_cnt_nx == TOTAL) begin
          valid_d = 1'b1;
          cand_d  = acc_nx;
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      issue_cnt_q   <= '0;
      resp_cnt_q    <= '0;
      acc_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      sub_en_q      <= 1'b0;
      sub_pos_q     <= '0;
      sub_central_q <= '0;
      sub_rsq_q     <= '0;
      sub_mode_q    <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      cand_q        <= '0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      resp_cnt_q    <= resp_cnt_d;
      acc_q         <= acc_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sub_en_q      <= sub_en_d;
      sub_pos_q     <= sub_pos_d;
      sub_central_q <= sub_central_d;
      sub_rsq_q     <= sub_rsq_d;
      sub_mode_q    <= sub_mode_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      cand_q        <= cand_d;
    end
  end

  assign sub_en            = sub_en_q;
  assign sub_position      = sub_pos_q;
  assign sub_central       = sub_central_q;
  assign sub_radius_square = sub_rsq_q;
  assign sub_mode          = sub_mode_q;
  assign busy              = busy_q;
  assign valid             = valid_q;
  assign candidate         = cand_q;

endmodule

// File: tb/tb_subset_scan_ctrl.sv
// Drives subset_scan_ctrl against a Subset stub with selectable latency and a
// per-point activation table; expected counts come from the table's population.
module tb_subset_scan_ctrl;

  localparam int GW   = 8;
  localparam int GH   = 8;
  localparam int CW   = 8;
  localparam int NPTS = GW * GH;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [23:0]   central;
  logic [23:0]   radius_square;
  logic [1:0]    mode;
  logic          sub_en;
  logic [23:0]   sub_central;
  logic [23:0]   sub_radius_square;
  logic [1:0]    sub_mode;
  logic [7:0]    sub_position;
  logic          sub_valid;
  logic          sub_activated;
  logic          busy;
  logic          valid;
  logic [CW-1:0] candidate;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  subset_scan_ctrl #(.GRID_W(GW), .GRID_H(GH), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .central           (central),
    .radius_square     (radius_square),
    .mode              (mode),
    .sub_en            (sub_en),
    .sub_central       (sub_central),
    .sub_radius_square (sub_radius_square),
    .sub_mode          (sub_mode),
    .sub_position      (sub_position),
    .sub_valid         (sub_valid),
    .sub_activated     (sub_activated),
    .busy              (busy),
    .valid             (valid),
    .candidate         (candidate)
  );

  // Subset stub: fixed latency 0..4, activation looked up from act_tab
  int          lat = 1;
  logic [63:0] act_tab = '0;
  logic        inj_v = 1'b0;
  logic        inj_a = 1'b0;
  logic [3:0]  pipe_v = '0;
  logic [3:0]  pipe_a = '0;
  logic        act_now;
  logic        stub_v;
  logic        stub_a;

  function automatic int pos_index(input logic [7:0] p);
    int x;
    int y;
    x = int'(p[7:4]);
    y = int'(p[3:0]);
    if (x < 1 || x > GW || y < 1 || y > GH) return -1;
    return (y - 1) * GW + (x - 1);
  endfunction

  function automatic logic act_of(input logic [7:0] p, input logic [63:0] tab);
    int ix;
    ix = pos_index(p);
    if (ix < 0) return 1'b0;
    return tab[ix];
  endfunction

  always_comb begin
    act_now = sub_en & act_of(sub_position, act_tab);
    case (lat)
      1:       begin stub_v = pipe_v[0]; stub_a = pipe_a[0]; end
      2:       begin stub_v = pipe_v[1]; stub_a = pipe_a[1]; end
      3:       begin stub_v = pipe_v[2]; stub_a = pipe_a[2]; end
      4:       begin stub_v = pipe_v[3]; stub_a = pipe_a[3]; end
      default: begin stub_v = sub_en;    stub_a = act_now;   end
    endcase
    sub_valid     = stub_v | inj_v;
    sub_activated = stub_a | inj_a;
  end

  always @(posedge clk) begin
    pipe_v <= {pipe_v[2:0], sub_en};
    pipe_a <= {pipe_a[2:0], act_now};
  end

  // Monitor samples on the falling edge and only ever accumulates
  int          cyc       = 0;
  int          valid_cnt = 0;
  int          busy_cnt  = 0;
  int          valid_cyc = 0;
  int          en_cyc    = 0;
  logic [CW-1:0] cand_at_valid = '0;
  logic [7:0]  issue_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (en && !busy) en_cyc = cyc;
    if (sub_en) issue_q.push_back(sub_position);
    if (busy) busy_cnt = busy_cnt + 1;
    if (valid) begin
      valid_cnt     = valid_cnt + 1;
      valid_cyc     = cyc;
      cand_at_valid = candidate;
    end
  end

  logic [CW-1:0] exp_cand = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] c, input logic [23:0] r, input logic [1:0] m);
    @(posedge clk);
    #1;
    en            = 1'b1;
    central       = c;
    radius_square = r;
    mode          = m;
    @(posedge clk);
    #1;
    en            = 1'b0;
    central       = $urandom;
    radius_square = $urandom;
    mode          = 2'($urandom);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sub_en"}, 32'(sub_en), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_candidate"}, 32'(candidate), 32'd0);
    checkOutput({tag, "_sub_position"}, 32'(sub_position), 32'd0);
    checkOutput({tag, "_sub_central"}, 32'(sub_central), 32'd0);
    checkOutput({tag, "_sub_rsq"}, 32'(sub_radius_square), 32'd0);
    checkOutput({tag, "_sub_mode"}, 32'(sub_mode), 32'd0);
  endtask

  task automatic runScan(input string name, input int l, input logic [63:0] tab,
                         input logic [1:0] m, input bit mid_en);
    int v0, b0, q0, errs, k, exp_cnt;
    logic [23:0] c, r;
    lat     = l;
    act_tab = tab;
    c       = $urandom;
    r       = $urandom;
    exp_cnt = $countones(tab);
    v0      = valid_cnt;
    b0      = busy_cnt;
    q0      = issue_q.size();
    applyStimulus(c, r, m);
    checkOutput({name, "_busy_rise"}, 32'(busy), 32'd1);
    checkOutput({name, "_cand_kept"}, 32'(candidate), 32'(exp_cand));
    checkOutput({name, "_sub_central"}, 32'(sub_central), 32'(c));
    for (int i = 0; i < 400 && valid_cnt == v0; i++) begin
      @(posedge clk);
      if (mid_en && i == 20) begin
        #1;
        en = 1'b1; central = ~c; radius_square = ~r; mode = ~m;
      end else if (mid_en && i == 21) begin
        #1;
        en = 1'b0;
      end
    end
    checkOutput({name, "_valid_seen"}, 32'(valid_cnt - v0), 32'd1);
    checkOutput({name, "_cand_at_valid"}, 32'(cand_at_valid), 32'(exp_cnt));
    checkOutput({name, "_latency"}, 32'(valid_cyc - en_cyc), 32'(NPTS + l + 2));
    repeat (5) @(posedge clk);
    checkOutput({name, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(NPTS + l + 2));
    checkOutput({name, "_one_valid"}, 32'(valid_cnt - v0), 32'd1);
    checkOutput({name, "_issue_count"}, 32'(issue_q.size() - q0), 32'(NPTS));
    errs = 0;
    k    = 0;
    for (int y = 1; y <= GH; y++) begin
      for (int x = 1; x <= GW; x++) begin
        if (q0 + k >= issue_q.size() || issue_q[q0 + k] !== {4'(x), 4'(y)}) errs++;
        k++;
      end
    end
    checkOutput({name, "_issue_order_errs"}, 32'(errs), 32'd0);
    checkOutput({name, "_cand_hold"}, 32'(candidate), 32'(exp_cnt));
    checkOutput({name, "_busy_low"}, 32'(busy), 32'd0);
    checkOutput({name, "_central_kept"}, 32'(sub_central), 32'(c));
    checkOutput({name, "_rsq_kept"}, 32'(sub_radius_square), 32'(r));
    checkOutput({name, "_mode_kept"}, 32'(sub_mode), 32'(m));
    exp_cand = CW'(exp_cnt);
  endtask

  initial begin
    logic [63:0] tab;
    int v0, q0;

    rst = 1'b1; en = 1'b0; central = '0; radius_square = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    $display("[TB] idle with random sub_valid");
    v0 = valid_cnt;
    q0 = issue_q.size();
    repeat (100) begin
      @(posedge clk);
      #1;
      inj_v = 1'($urandom);
      inj_a = 1'($urandom);
    end
    @(posedge clk);
    #1;
    inj_v = 1'b0;
    inj_a = 1'b0;
    checkOutput("idle_candidate", 32'(candidate), 32'd0);
    checkOutput("idle_no_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("idle_no_issue", 32'(issue_q.size() - q0), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] full sweep, latency 1, all activated");
    runScan("all1", 1, {64{1'b1}}, 2'($urandom), 1'b0);

    $display("[TB] latency 4, diagonal only");
    tab = '0;
    for (int i = 1; i <= 8; i++) tab[(i - 1) * GW + (i - 1)] = 1'b1;
    runScan("diag", 4, tab, 2'($urandom), 1'b0);

    $display("[TB] combinational feedback, 17 points");
    tab = '0;
    while ($countones(tab) < 17) tab[$urandom_range(63, 0)] = 1'b1;
    runScan("comb17", 0, tab, 2'b01, 1'b0);

    $display("[TB] en re-asserted mid-scan");
    runScan("midEn", 2, {$urandom, $urandom}, 2'($urandom), 1'b1);

    $display("[TB] reset at issue 30");
    lat     = 3;
    act_tab = {$urandom, $urandom};
    v0      = valid_cnt;
    q0      = issue_q.size();
    applyStimulus($urandom, $urandom, 2'($urandom));
    for (int i = 0; i < 200 && issue_q.size() - q0 < 30; i++) @(posedge clk);
    checkOutput("abort_at_issue", 32'(issue_q.size() - q0), 32'd30);
    #1;
    rst = 1'b1;
    #1;
    checkResetOutputs("abort");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    checkOutput("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("abort_candidate", 32'(candidate), 32'd0);
    exp_cand = '0;
    runScan("afterAbort", 3, {$urandom, $urandom}, 2'($urandom), 1'b0);

    $display("[TB] random latency and table");
    runScan("rand", int'($urandom_range(4, 0)), {$urandom, $urandom}, 2'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
